// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
package branch_pkg;

   typedef enum logic [2:0] {
      EQ = 3'd0,
      NE = 3'd1,
      C  = 3'd2,
      NC = 3'd3,
      N  = 3'd4,
      GE = 3'd5,
      LT = 3'd6,
      AL = 3'd7
   } cond_e;

   typedef enum logic {
      IDLE   = 1'b0,
      SQUASH = 1'b1
   } br_state_e;

   localparam logic [2:0]  OPC_BL    = 3'b000;
   localparam logic [2:0]  OPC_BCOND = 3'b001;
   localparam logic [15:0] CNT_MAX   = 16'hFFFF;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == CNT_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Execute-stage branch bus: branch operands in, redirect/LR/flush/statistics out.
interface branch_resolver_if;

   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_bl;
   logic [2:0]  ex_cond;
   logic        ex_pred_taken;
   logic [3:0]  psw_flags;
   logic [15:0] ex_target;
   logic [15:0] ex_lbpc;
   logic [15:0] ex_lbpc_lr;
   logic [15:0] ex_lbpsw;

   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        flush;
   logic        psw_restore_valid;
   logic [15:0] psw_restore;
   logic        lr_we;
   logic [15:0] lr_data;
   logic        busy;
   logic [15:0] branch_count;
   logic [15:0] mispredict_count;

   modport master (
      output ex_valid, ex_is_branch, ex_is_bl, ex_cond, ex_pred_taken, psw_flags,
             ex_target, ex_lbpc, ex_lbpc_lr, ex_lbpsw,
      input  redirect_valid, redirect_pc, flush, psw_restore_valid, psw_restore,
             lr_we, lr_data, busy, branch_count, mispredict_count
   );

   modport slave (
      input  ex_valid, ex_is_branch, ex_is_bl, ex_cond, ex_pred_taken, psw_flags,
             ex_target, ex_lbpc, ex_lbpc_lr, ex_lbpsw,
      output redirect_valid, redirect_pc, flush, psw_restore_valid, psw_restore,
             lr_we, lr_data, busy, branch_count, mispredict_count
   );

endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluation against PSW flags {V,N,Z,C}.
module branch_cond_eval
   import branch_pkg::*;
(
   input  cond_e      cond,
   input  logic [3:0] psw_flags,
   input  logic       is_bl,
   output logic       taken
);

   logic v, n, z, c;
   assign {v, n, z, c} = psw_flags;

   always_comb begin
      taken = 1'b0;
      if (is_bl) begin
         taken = 1'b1;
      end else begin
         case (cond)
            EQ:      taken = z;
            NE:      taken = ~z;
            C:       taken = c;
            NC:      taken = ~c;
            N:       taken = n;
            GE:      taken = ~(n ^ v);
            LT:      taken = n ^ v;
            AL:      taken = 1'b1;
            default: taken = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: mispredict redirect, PSW restore, timed flush,
// BL link-register write and saturating branch statistics.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic              clk,
   input logic              rst_n,
   branch_resolver_if.slave bus
);

   localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

   br_state_e   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [15:0] redirect_pc_q, redirect_pc_d;
   logic        psw_restore_valid_q, psw_restore_valid_d;
   logic [15:0] psw_restore_q, psw_restore_d;
   logic        lr_we_q, lr_we_d;
   logic [15:0] lr_data_q, lr_data_d;
   logic        flush_q, flush_d;
   logic        busy_q, busy_d;
   logic [15:0] branch_count_q, branch_count_d;
   logic [15:0] mispredict_count_q, mispredict_count_d;

   cond_e       ex_cond_e;
   logic        actual_taken;
   logic        resolve;
   logic        mispredict;
   logic [15:0] corrected_pc;

   assign ex_cond_e = cond_e'(bus.ex_cond);

   branch_cond_eval u_cond (
      .cond      (ex_cond_e),
      .psw_flags (bus.psw_flags),
      .is_bl     (bus.ex_is_bl),
      .taken     (actual_taken)
   );

   // Only IDLE resolves: anything presented during SQUASH is wrong-path.
   assign resolve      = bus.ex_valid & bus.ex_is_branch & (state_q == IDLE);
   assign mispredict   = resolve & (bus.ex_pred_taken != actual_taken);
   assign corrected_pc = actual_taken ? bus.ex_target : bus.ex_lbpc;

   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      redirect_valid_d    = mispredict;
      psw_restore_valid_d = mispredict;
      redirect_pc_d       = redirect_pc_q;
      psw_restore_d       = psw_restore_q;
      lr_we_d             = resolve & bus.ex_is_bl;
      lr_data_d           = lr_data_q;
      branch_count_d      = branch_count_q;
      mispredict_count_d  = mispredict_count_q;

      case (state_q)
         IDLE: begin
            if (mispredict) begin
               state_d = SQUASH;
               cnt_d   = CNT_LOAD;
            end
         end
         SQUASH: begin
            if (cnt_q == 3'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 3'd1;
         end
         default: state_d = IDLE;
      endcase

      if (mispredict) begin
         redirect_pc_d = {corrected_pc[15:1], 1'b0};
         psw_restore_d = bus.ex_lbpsw;
      end
      if (resolve & bus.ex_is_bl) lr_data_d = bus.ex_lbpc_lr;
      if (resolve)                branch_count_d = sat_inc(branch_count_q);
      if (mispredict)             mispredict_count_d = sat_inc(mispredict_count_q);

      // Registered copies of the next state, so flush/busy align with SQUASH.
      flush_d = (state_d == SQUASH);
      busy_d  = (state_d == SQUASH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q             <= IDLE;
         cnt_q               <= '0;
         redirect_valid_q    <= 1'b0;
         redirect_pc_q       <= '0;
         psw_restore_valid_q <= 1'b0;
         psw_restore_q       <= '0;
         lr_we_q             <= 1'b0;
         lr_data_q           <= '0;
         flush_q             <= 1'b0;
         busy_q              <= 1'b0;
         branch_count_q      <= '0;
         mispredict_count_q  <= '0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         redirect_valid_q    <= redirect_valid_d;
         redirect_pc_q       <= redirect_pc_d;
         psw_restore_valid_q <= psw_restore_valid_d;
         psw_restore_q       <= psw_restore_d;
         lr_we_q             <= lr_we_d;
         lr_data_q           <= lr_data_d;
         flush_q             <= flush_d;
         busy_q              <= busy_d;
         branch_count_q      <= branch_count_d;
         mispredict_count_q  <= mispredict_count_d;
      end
   end

   assign bus.redirect_valid    = redirect_valid_q;
   assign bus.redirect_pc       = redirect_pc_q;
   assign bus.psw_restore_valid = psw_restore_valid_q;
   assign bus.psw_restore       = psw_restore_q;
   assign bus.lr_we             = lr_we_q;
   assign bus.lr_data           = lr_data_q;
   assign bus.flush             = flush_q;
   assign bus.busy              = busy_q;
   assign bus.branch_count      = branch_count_q;
   assign bus.mispredict_count  = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed branches push expected redirect/LR
// events; a negedge monitor pops and compares whenever a pulse appears.
module tb_branch_resolver;
   import branch_pkg::*;

   localparam int unsigned FC = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_resolver_if bus ();

   branch_resolver #(.FLUSH_CYCLES(FC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   cond_e      model_cond;
   logic [3:0] model_flags;
   logic       model_taken;

   branch_cond_eval u_model (
      .cond      (model_cond),
      .psw_flags (model_flags),
      .is_bl     (1'b0),
      .taken     (model_taken)
   );

   typedef struct {
      logic        rv;
      logic [15:0] pc;
      logic [15:0] psw;
      logic        lrwe;
      logic [15:0] lrd;
      logic [15:0] bc;
      logic [15:0] mc;
   } ev_t;

   ev_t         exp_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_bc = 16'h0;
   logic [15:0] exp_mc = 16'h0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Hand-written truth table over flags {V,N,Z,C}.
   function automatic logic ref_taken(input logic is_bl, input logic [2:0] cond, input logic [3:0] f);
      if (is_bl) return 1'b1;
      case (cond)
         3'd0: return f[1];
         3'd1: return !f[1];
         3'd2: return f[0];
         3'd3: return !f[0];
         3'd4: return f[2];
         3'd5: return f[2] == f[3];
         3'd6: return f[2] != f[3];
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [15:0] inc_sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? 16'hFFFF : v + 16'h1;
   endfunction

   task automatic idle_inputs();
      bus.ex_valid      = 1'b0;
      bus.ex_is_branch  = 1'b0;
      bus.ex_is_bl      = 1'b0;
      bus.ex_cond       = 'x;
      bus.ex_pred_taken = 'x;
      bus.psw_flags     = 'x;
      bus.ex_target     = 'x;
      bus.ex_lbpc       = 'x;
      bus.ex_lbpc_lr    = 'x;
      bus.ex_lbpsw      = 'x;
   endtask

   task automatic drive(input logic is_bl, input logic [2:0] cond, input logic pred,
                        input logic [3:0] flags, input logic [15:0] tgt, input logic [15:0] lbpc,
                        input logic [15:0] lr, input logic [15:0] psw);
      bus.ex_valid      = 1'b1;
      bus.ex_is_branch  = 1'b1;
      bus.ex_is_bl      = is_bl;
      bus.ex_cond       = cond;
      bus.ex_pred_taken = pred;
      bus.psw_flags     = flags;
      bus.ex_target     = tgt;
      bus.ex_lbpc       = lbpc;
      bus.ex_lbpc_lr    = lr;
      bus.ex_lbpsw      = psw;
   endtask

   // Issue a resolvable branch at a negedge, update the model, push any expected event.
   task automatic issue(input logic is_bl, input logic [2:0] cond, input logic pred,
                        input logic [3:0] flags, input logic [15:0] tgt, input logic [15:0] lbpc,
                        input logic [15:0] lr, input logic [15:0] psw, output logic mis);
      logic        act;
      logic [15:0] pc;
      drive(is_bl, cond, pred, flags, tgt, lbpc, lr, psw);
      act = ref_taken(is_bl, cond, flags);
      mis = (pred != act);
      pc  = act ? tgt : lbpc;
      pc[0] = 1'b0;
      exp_bc = inc_sat(exp_bc);
      if (mis) exp_mc = inc_sat(exp_mc);
      if (mis || is_bl)
         exp_q.push_back('{rv: mis, pc: pc, psw: psw, lrwe: is_bl, lrd: lr, bc: exp_bc, mc: exp_mc});
   endtask

   // Full branch: issue, then check counters and the whole flush window.
   task automatic branch(input logic is_bl, input logic [2:0] cond, input logic pred,
                         input logic [3:0] flags, input logic [15:0] tgt, input logic [15:0] lbpc,
                         input logic [15:0] lr, input logic [15:0] psw);
      logic mis;
      issue(is_bl, cond, pred, flags, tgt, lbpc, lr, psw, mis);
      @(negedge clk);
      idle_inputs();
      chk("branch_count", bus.branch_count, exp_bc);
      chk("mispredict_count", bus.mispredict_count, exp_mc);
      chk("flush_first", 16'(bus.flush), 16'(mis));
      chk("busy_first", 16'(bus.busy), 16'(mis));
      if (mis) begin
         for (int unsigned i = 1; i < FC; i++) begin
            @(negedge clk);
            chk("flush_hold", 16'(bus.flush), 16'h1);
            chk("busy_hold", 16'(bus.busy), 16'h1);
         end
         @(negedge clk);
         chk("flush_end", 16'(bus.flush), 16'h0);
         chk("busy_end", 16'(bus.busy), 16'h0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_redirect_valid"}, 16'(bus.redirect_valid), 16'h0);
      chk({tag, "_psw_restore_valid"}, 16'(bus.psw_restore_valid), 16'h0);
      chk({tag, "_lr_we"}, 16'(bus.lr_we), 16'h0);
      chk({tag, "_flush"}, 16'(bus.flush), 16'h0);
      chk({tag, "_busy"}, 16'(bus.busy), 16'h0);
      chk({tag, "_redirect_pc"}, bus.redirect_pc, 16'h0);
      chk({tag, "_psw_restore"}, bus.psw_restore, 16'h0);
      chk({tag, "_lr_data"}, bus.lr_data, 16'h0);
      chk({tag, "_branch_count"}, bus.branch_count, 16'h0);
      chk({tag, "_mispredict_count"}, bus.mispredict_count, 16'h0);
   endtask

   // Monitor: every redirect/LR pulse must match the next expected event.
   always @(negedge clk) begin
      ev_t e;
      if (bus.redirect_valid === 1'b1 || bus.psw_restore_valid === 1'b1 || bus.lr_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: redirect_valid=%b lr_we=%b expected no event at %0t",
                     bus.redirect_valid, bus.lr_we, $time);
         end else begin
            e = exp_q.pop_front();
            chk("ev_redirect_valid", 16'(bus.redirect_valid), 16'(e.rv));
            chk("ev_psw_restore_valid", 16'(bus.psw_restore_valid), 16'(e.rv));
            if (e.rv) begin
               chk("ev_redirect_pc", bus.redirect_pc, e.pc);
               chk("ev_psw_restore", bus.psw_restore, e.psw);
            end
            chk("ev_lr_we", 16'(bus.lr_we), 16'(e.lrwe));
            if (e.lrwe) chk("ev_lr_data", bus.lr_data, e.lrd);
            chk("ev_branch_count", bus.branch_count, e.bc);
            chk("ev_mispredict_count", bus.mispredict_count, e.mc);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic mis;
      idle_inputs();
      model_cond  = EQ;
      model_flags = 4'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;

      // BEQ predicted taken, Z=0: redirect to fallthrough, restore PSW.
      branch(1'b0, 3'd0, 1'b1, 4'b0000, 16'h0200, 16'h0102, 16'h0000, 16'h0004);
      // BNE predicted taken, Z=0: correct, counts only.
      branch(1'b0, 3'd1, 1'b1, 4'b0000, 16'h0300, 16'h0104, 16'h0000, 16'h0008);
      // BL predicted not taken: redirect to target with bit 0 cleared, LR write.
      branch(1'b1, 3'd5, 1'b0, 4'b0000, 16'h0A01, 16'h0300, 16'h0040, 16'h1234);
      // BL predicted taken: LR write only.
      branch(1'b1, 3'd0, 1'b1, 4'b0010, 16'h0B00, 16'h0400, 16'h0042, 16'h0000);

      // Valid non-branch: no action.
      bus.ex_valid = 1'b1;
      bus.ex_is_branch = 1'b0;
      bus.ex_is_bl = 1'b1;
      bus.ex_pred_taken = 1'b0;
      @(negedge clk);
      idle_inputs();
      chk("nonbranch_branch_count", bus.branch_count, exp_bc);
      chk("nonbranch_flush", 16'(bus.flush), 16'h0);

      // BRA mispredict, then wrong-path BL/BRA during both SQUASH cycles.
      issue(1'b0, 3'd7, 1'b0, 4'b0000, 16'h0800, 16'h0500, 16'h0000, 16'h0011, mis);
      for (int unsigned i = 0; i < FC; i++) begin
         @(negedge clk);
         chk("squash_busy", 16'(bus.busy), 16'h1);
         chk("squash_branch_count", bus.branch_count, exp_bc);
         drive(1'b1, 3'd7, 1'b0, 4'b0000, 16'h0900, 16'h0600, 16'h0077, 16'h0022);
      end
      @(negedge clk);
      chk("squash_ignored_branch_count", bus.branch_count, exp_bc);
      chk("squash_ignored_mispredict_count", bus.mispredict_count, exp_mc);
      chk("squash_exit_busy", 16'(bus.busy), 16'h0);
      // First IDLE cycle after SQUASH resolves normally.
      branch(1'b0, 3'd7, 1'b0, 4'b0000, 16'h0A00, 16'h0700, 16'h0000, 16'h0033);

      // Saturation: preload both counters just below the limit.
      @(negedge clk);
      force dut.branch_count_q = 16'hFFFE;
      force dut.mispredict_count_q = 16'hFFFE;
      @(negedge clk);
      release dut.branch_count_q;
      release dut.mispredict_count_q;
      exp_bc = 16'hFFFE;
      exp_mc = 16'hFFFE;
      repeat (3) branch(1'b0, 3'd0, 1'b1, 4'b0000, 16'h0C00, 16'h0C02, 16'h0000, 16'h0044);
      chk("sat_mispredict_count", bus.mispredict_count, 16'hFFFF);
      chk("sat_branch_count", bus.branch_count, 16'hFFFF);

      // Reset in the middle of SQUASH.
      issue(1'b0, 3'd2, 1'b1, 4'b0000, 16'h0D00, 16'h0D10, 16'h0000, 16'h0055, mis);
      @(negedge clk);
      idle_inputs();
      chk("pre_reset_flush", 16'(bus.flush), 16'h1);
      rst_n = 1'b0;
      @(negedge clk);
      check_all_zero("midsquash_reset");
      rst_n = 1'b1;
      exp_bc = 16'h0;
      exp_mc = 16'h0;
      // Resolving immediately proves the state is IDLE.
      branch(1'b0, 3'd7, 1'b1, 4'b0000, 16'h0E00, 16'h0E02, 16'h0000, 16'h0000);
      chk("post_reset_branch_count", bus.branch_count, 16'h1);

      // Condition sweep: 8 conditions x 16 flag patterns, predicted not taken.
      for (int unsigned c = 0; c < 8; c++) begin
         for (int unsigned f = 0; f < 16; f++) begin
            model_cond  = cond_e'(c[2:0]);
            model_flags = f[3:0];
            #1;
            chk("cond_eval_model", 16'(model_taken), 16'(ref_taken(1'b0, c[2:0], f[3:0])));
            branch(1'b0, c[2:0], 1'b0, f[3:0], {4'h2, 5'h0, c[2:0], f[3:0]},
                   {4'h3, 5'h0, c[2:0], f[3:0]}, 16'h0000, {12'h0, f[3:0]});
         end
      end

      @(negedge clk);
      chk("pending_events", 16'(exp_q.size()), 16'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage branch resolution unit. It is the consumer of the fetch-side taken-branch prediction and its saved fallthrough PC and PSW. For every branch that reaches execute, it evaluates the real condition against the current PSW flags and compares the result with the prediction. On a mismatch it issues a registered PC redirect and a PSW restore, then holds a multi-cycle flush of the wrong-path stages. It also writes LR for BL and keeps saturating statistics counters.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles `flush` stays high after a mispredict. Range 1..7.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset: synchronous, active-low.
- ex_valid  in  1  execute stage holds a real (non-bubble) instruction.
- ex_is_branch  in  1  instruction is a conditional branch (opcode 001) or BL (opcode 000).
- ex_is_bl  in  1  instruction is BL; it is always taken.
- ex_cond  in  3  condition field of the conditional branch.
- ex_pred_taken  in  1  prediction made at fetch.
- psw_flags  in  4  current {V,N,Z,C}.
- ex_target  in  16  resolved branch target.
- ex_lbpc  in  16  saved fallthrough PC.
- ex_lbpc_lr  in  16  saved return address for BL.
- ex_lbpsw  in  16  PSW saved at prediction time.
- redirect_valid  out  1  one-cycle pulse; fetch must load `redirect_pc`.
- redirect_pc  out  16  corrected PC; bit 0 is always 0.
- flush  out  1  kill fetch and decode contents; also suppresses hazard-stage dependency capture.
- psw_restore_valid  out  1  one-cycle pulse, coincident with `redirect_valid`.
- psw_restore  out  16  PSW value to reinstate.
- lr_we  out  1  one-cycle LR write strobe.
- lr_data  out  16  LR write value.
- busy  out  1  high while in SQUASH.
- branch_count  out  16  resolved branches, saturating.
- mispredict_count  out  16  mispredicts, saturating.

## Operation
Condition decode for opcode 001, with `ex_cond` values 0–7:
- 0 BEQ: Z
- 1 BNE: !Z
- 2 BC: C
- 3 BNC: !C
- 4 BN: N
- 5 BGE: !(N^V)
- 6 BLT: N^V
- 7 BRA: 1
- BL ignores `ex_cond`; `actual_taken` = 1.

Resolve condition: `resolve` = `ex_valid & ex_is_branch & (state==IDLE)`.

Mispredict condition: `mispredict` = `resolve & (ex_pred_taken != actual_taken)`.

On a mispredict cycle:
- Corrected PC = `actual_taken ? ex_target : ex_lbpc`, bit 0 forced to 0.
- PSW restore value = `ex_lbpsw`.

FSM has two states:
- IDLE:
  - `mispredict` goes to SQUASH and loads cnt = FLUSH_CYCLES−1.
  - Otherwise it stays in IDLE.
- SQUASH:
  - `flush` = 1 and `busy` = 1.
  - `ex_valid` is ignored, because the instruction is wrong-path.
  - If cnt==0, go to IDLE; otherwise decrement cnt.

Outputs and counters:
- `lr_we` pulses for any resolved BL (`resolve & ex_is_bl`), regardless of prediction, with `lr_data` = `ex_lbpc_lr`.
- `branch_count` increments on `resolve`.
- `mispredict_count` increments on `mispredict`.
- Both counters saturate at 0xFFFF; there is no wrap.

Boundary cases:
- A branch arriving during SQUASH is not resolved, counted, or allowed to write LR.
- A branch in the first IDLE cycle after SQUASH is resolved normally.
- `ex_is_branch`=0 with `ex_valid`=1 produces no action.
- X on the data inputs is ignored when `resolve`=0.
- Reset mid-SQUASH: the next cycle is IDLE, all outputs are 0, and the counters are 0.

## Timing
- Reset values:
  - state IDLE, cnt 0.
  - `redirect_valid`, `psw_restore_valid`, `lr_we`, `flush`, `busy` all 0.
  - `redirect_pc`, `psw_restore`, `lr_data` all 0x0000.
  - Both counters 0.
- All outputs are registered, giving a latency of 1 cycle:
  - A mispredict detected in cycle N gives `redirect_valid`, `psw_restore_valid` and `flush` = 1 in cycle N+1.
  - `flush` and `busy` hold through cycle N+FLUSH_CYCLES.
  - The state is IDLE again in cycle N+FLUSH_CYCLES+1.
- Redirect and PSW outputs:
  - `redirect_pc` and `psw_restore` hold their last value between pulses.
  - The pulses last exactly 1 cycle.
- `lr_we` is asserted in cycle N+1 for a BL resolved in cycle N.
  - If the BL also mispredicts, `lr_we` and `redirect_valid` coincide.
- Counters update at the same edge that registers the event, so they are visible in N+1.

## Structure
- Package `branch_pkg`:
  - enum `cond_e`: EQ, NE, C, NC, N, GE, LT, AL.
  - enum `br_state_e`: IDLE, SQUASH.
  - localparams `OPC_BL`=3'b000 and `OPC_BCOND`=3'b001.
  - localparam `CNT_MAX`=16'hFFFF.
- Sub-module `branch_cond_eval`:
  - Purely combinational.
  - Inputs: `cond_e`, `psw_flags`, `is_bl`. Output: `taken`.
  - Reused by the verification scoreboard.

## Test plan
1. BEQ, pred_taken=1, Z=0, ex_lbpc=0x0102, ex_lbpsw=0x0004, FLUSH_CYCLES=2:
   - Cycle N+1: redirect_valid=1, redirect_pc=0x0102, psw_restore=0x0004.
   - flush high for 2 cycles.
   - mispredict_count=1.
2. BNE, pred_taken=1, Z=0:
   - No redirect, no flush.
   - branch_count increments, mispredict_count unchanged.
3. BL, pred_taken=0, ex_target=0x0A01, ex_lbpc_lr=0x0040:
   - Cycle N+1: redirect_pc=0x0A00, lr_we=1, lr_data=0x0040.
4. Mispredict, then a valid BRA presented during both SQUASH cycles:
   - The BRA is ignored: counters unchanged, no second redirect.
   - A BRA in the first IDLE cycle after SQUASH is resolved.
5. Saturation and reset:
   - Force 0x10000 mispredicts: mispredict_count stays at 0xFFFF.
   - rst_n=0 asserted mid-SQUASH: the next cycle has all outputs 0 and the state is IDLE.
6. Condition sweep: all 8 `ex_cond` values × 16 `psw_flags` combinations, each compared against the `branch_cond_eval` model; GE/LT checked with N≠V.
